// File: rtl/inv_cipher_iter.sv
// Iterative AES inverse cipher: one decryption round per clock on a single
// 128-bit block, with valid/ready on both sides, a round-key request port
// and a sideband tag that travels with the block untouched.
// Byte b of a block sits at [127-8*b -: 8]; byte b is row b%4, column b/4.

// AES inverse S-box: inverse affine map, then GF(2^8) inverse as x^254.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, v;
    p = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ v;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^2 * x^4 * ... * x^128 = x^254; zero maps to zero for free
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] p, r;
    p = gmul(x, x);
    r = p;
    for (int i = 2; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;
  assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  assign y = ginv(b);
endmodule

// InvMixColumns on one column; a[31:24] is row 0.
module inv_mix_col (
  input  logic [31:0] a,
  output logic [31:0] y
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // multiply by a constant whose bits select x, 2x, 4x, 8x
  function automatic logic [7:0] mulc(input logic [7:0] x, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(x);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[0] ? x : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = a;
  assign y[31:24] = mulc(a0, 4'he) ^ mulc(a1, 4'hb) ^ mulc(a2, 4'hd) ^ mulc(a3, 4'h9);
  assign y[23:16] = mulc(a0, 4'h9) ^ mulc(a1, 4'he) ^ mulc(a2, 4'hb) ^ mulc(a3, 4'hd);
  assign y[15:8]  = mulc(a0, 4'hd) ^ mulc(a1, 4'h9) ^ mulc(a2, 4'he) ^ mulc(a3, 4'hb);
  assign y[7:0]   = mulc(a0, 4'hb) ^ mulc(a1, 4'hd) ^ mulc(a2, 4'h9) ^ mulc(a3, 4'he);
endmodule

module inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int TAG_W = 1,
  parameter int KI_W  = $clog2(NR + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [TAG_W-1:0] in_tag,
  output logic [KI_W-1:0]  key_idx,
  input  logic [127:0]     key_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [KI_W-1:0] RC_LAST = KI_W'(NR);

  logic [1:0]       state;
  logic [127:0]     st, ark, imc, pre, isr, isb;
  logic [TAG_W-1:0] tag;
  logic [KI_W-1:0]  rc;
  logic             accept;

  assign ark = st ^ key_in;

  genvar gc, gb;
  generate
    for (gc = 0; gc < 4; gc++) begin : g_col
      inv_mix_col u_col (.a(ark[127-32*gc -: 32]), .y(imc[127-32*gc -: 32]));
    end
  endgenerate

  // the first round after accept skips InvMixColumns
  assign pre = (rc == RC_LAST) ? ark : imc;

  generate
    for (gb = 0; gb < 16; gb++) begin : g_byte
      // row r rotates right by r: out(r,c) takes in(r,c-r)
      localparam int R   = gb % 4;
      localparam int C   = gb / 4;
      localparam int SRC = 4 * ((C + 4 - R) % 4) + R;
      assign isr[127-8*gb -: 8] = pre[127-8*SRC -: 8];
      inv_sbox u_sb (.a(isr[127-8*gb -: 8]), .y(isb[127-8*gb -: 8]));
    end
  endgenerate

  assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign key_idx   = (state == S_ROUND) ? rc : '0;
  assign out_valid = (state == S_DONE);
  assign out_data  = st;
  assign out_tag   = tag;

  // round sequencer; a new block may be accepted straight out of DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_IDLE;
      st    <= '0;
      tag   <= '0;
      rc    <= '0;
    end else begin
      case (state)
        S_ROUND: begin
          if (rc == '0) begin
            st    <= ark;
            state <= S_DONE;
          end else begin
            st <= isb;
            rc <= rc - KI_W'(1);
          end
        end
        S_DONE:  if (out_ready && !in_valid) state <= S_IDLE;
        S_IDLE:  ;
        default: state <= S_IDLE;
      endcase
      if (accept) begin
        st    <= in_data;
        tag   <= in_tag;
        rc    <= RC_LAST;
        state <= S_ROUND;
      end
    end
  end
endmodule

// File: tb/tb_inv_cipher_iter.sv
// Bench for inv_cipher_iter: an NR=10 and an NR=14 instance, a FIPS-197
// style reference decryptor built from its own S-box tables and key
// expansion, known-answer vectors plus randomized blocks.
module tb_inv_cipher_iter;
  logic clk = 1'b0;
  logic n_rst, iv, ordy, sel;
  logic [127:0] id;
  logic [3:0] it;
  logic ir10, ov10, ir14, ov14, ot10;
  logic [3:0] ki10, ki14, ot14;
  logic [127:0] kin10, kin14, od10, od14;
  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic cur_ready, cur_ov;
  logic [127:0] cur_od;
  logic [3:0] cur_ot, cur_kidx;
  int ntests = 0, nfail = 0, cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign kin10 = rk10[ki10];
  assign kin14 = rk14[ki14];
  assign cur_ready = sel ? ir14 : ir10;
  assign cur_ov    = sel ? ov14 : ov10;
  assign cur_od    = sel ? od14 : od10;
  assign cur_ot    = sel ? ot14 : {3'b000, ot10};
  assign cur_kidx  = sel ? ki14 : ki10;

  inv_cipher_iter #(.NR(10), .TAG_W(1)) u10 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv & ~sel), .in_ready(ir10),
    .in_data(id), .in_tag(it[0]), .key_idx(ki10), .key_in(kin10),
    .out_valid(ov10), .out_ready(ordy), .out_data(od10), .out_tag(ot10));

  inv_cipher_iter #(.NR(14), .TAG_W(4)) u14 (
    .clk(clk), .n_rst(n_rst), .in_valid(iv & sel), .in_ready(ir14),
    .in_data(id), .in_tag(it), .key_idx(ki14), .key_in(kin14),
    .out_valid(ov14), .out_ready(ordy), .out_data(od14), .out_tag(ot14));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, v;
    p = '0;
    v = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ v;
      v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] mcoef(input int k);
    case (k)
      0: return 8'h0e;
      1: return 8'h0b;
      2: return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] rkey(input int nr, input int i);
    return (nr == 10) ? rk10[i] : rk14[i];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] t);
    return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [64];
    logic [31:0] tmp;
    logic [7:0] rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nr == 10) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else          rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // textbook InvCipher ordering: key add, then rounds of
  // InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns
  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] acc;
    logic [127:0] v;
    v = ct ^ rkey(nr, nr);
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[4*c+r] = isb[s[4*((c+4-r)%4)+r]];
      for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
      v = v ^ rkey(nr, rnd);
      if (rnd > 0) begin
        for (int b = 0; b < 16; b++) s[b] = v[127-8*b -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(s[4*c+j], mcoef((j - r + 4) % 4));
            t[4*c+r] = acc;
          end
        for (int b = 0; b < 16; b++) v[127-8*b -: 8] = t[b];
      end
    end
    return v;
  endfunction

  // call at a negedge; returns just after the accept edge
  task automatic present(input logic [127:0] ct, input logic [3:0] tg);
    int n;
    n = 0;
    id = ct;
    it = tg;
    iv = 1'b1;
    #1;
    while (!cur_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    iv = 1'b0;
  endtask

  task automatic finish(input int nr, input logic [127:0] exp, input logic [3:0] etg, input bit seq);
    logic early;
    early = 1'b0;
    for (int k = 0; k <= nr; k++) begin
      @(negedge clk);
      early = early | cur_ov;
      if (seq) chk("kidx_seq", cur_kidx, 128'(nr - k));
    end
    chk("early_ovalid", early, 1'b0);
    @(negedge clk);
    chk("ovalid", cur_ov, 1'b1);
    chk("pt", cur_od, exp);
    chk("tag", cur_ot, etg);
    chk("kidx_done", cur_kidx, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv, s;
    logic [255:0] key;
    logic [127:0] ct, blkb;
    logic [127:0] blk [4];
    logic [3:0] btg [4];
    logic [3:0] tg;
    logic early;
    int acc [4];
    int nr, n;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end

    n_rst = 1'b0; iv = 1'b0; ordy = 1'b1; sel = 1'b0; id = '0; it = '0;
    #2;
    chk("rst_ready10", ir10, 1'b1);
    chk("rst_ovalid10", ov10, 1'b0);
    chk("rst_data10", od10, 128'h0);
    chk("rst_tag10", ot10, 1'b0);
    chk("rst_kidx10", ki10, 4'd0);
    chk("rst_ready14", ir14, 1'b1);
    chk("rst_ovalid14", ov14, 1'b0);
    chk("rst_data14", od14, 128'h0);
    chk("rst_tag14", ot14, 4'd0);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // AES-128 known answer with key index sequence
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    present(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h1);
    finish(10, 128'h00112233445566778899aabbccddeeff, 4'h1, 1'b1);
    @(negedge clk);
    chk("idle_kidx", cur_kidx, 4'd0);
    chk("idle_ovalid", cur_ov, 1'b0);
    chk("idle_ready", cur_ready, 1'b1);

    // backpressure with a second block waiting
    ordy = 1'b0;
    blkb = {$urandom, $urandom, $urandom, $urandom};
    present(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h1);
    finish(10, 128'h00112233445566778899aabbccddeeff, 4'h1, 1'b0);
    id = blkb; it = 4'h0; iv = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ovalid", cur_ov, 1'b1);
      chk("bp_data", cur_od, 128'h00112233445566778899aabbccddeeff);
      chk("bp_tag", cur_ot, 4'h1);
      chk("bp_ready", cur_ready, 1'b0);
      chk("bp_kidx", cur_kidx, 4'd0);
    end
    ordy = 1'b1;
    present(blkb, 4'h0);
    finish(10, ref_dec(blkb, 10), 4'h0, 1'b0);

    // reset in the middle of a block
    present(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h1);
    n = 0;
    while (cur_kidx != 4'd5 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach5", cur_kidx, 4'd5);
    n_rst = 1'b0;
    #1;
    chk("midrst_ovalid", cur_ov, 1'b0);
    chk("midrst_ready", cur_ready, 1'b1);
    chk("midrst_kidx", cur_kidx, 4'd0);
    @(negedge clk);
    n_rst = 1'b1;
    early = 1'b0;
    repeat (15) begin
      @(negedge clk);
      early = early | cur_ov;
    end
    chk("midrst_no_out", early, 1'b0);
    present(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 4'h1);
    finish(10, 128'h00112233445566778899aabbccddeeff, 4'h1, 1'b0);

    // AES-256 known answer on the deep instance
    sel = 1'b1;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    present(128'h8ea2b7ca516745bfeafc49904b496089, 4'hA);
    finish(14, 128'h00112233445566778899aabbccddeeff, 4'hA, 1'b1);
    @(negedge clk);
    sel = 1'b0;

    // back-to-back streaming, random key and blocks
    key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    expand(key, 10);
    for (int i = 0; i < 4; i++) begin
      blk[i] = {$urandom, $urandom, $urandom, $urandom};
      btg[i] = 4'($urandom_range(0, 1));
    end
    for (int i = 0; i < 4; i++) begin
      present(blk[i], btg[i]);
      acc[i] = acc_cyc;
      finish(10, ref_dec(blk[i], 10), btg[i], 1'b0);
    end
    for (int i = 1; i < 4; i++) chk("stream_period", 128'(acc[i] - acc[i-1]), 128'd12);
    @(negedge clk);

    // random keys, blocks, tags and engine depth
    repeat (8) begin
      sel = 1'($urandom_range(0, 1));
      nr = sel ? 14 : 10;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      tg = 4'($urandom_range(0, sel ? 15 : 1));
      expand(key, nr);
      present(ct, tg);
      finish(nr, ref_dec(ct, nr), tg, 1'b1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
